// File: rtl/vertex_pkg.sv
// vertex_pkg: shared sizes, types and helpers for the geometry store.
//   Sizes   : vertex/triangle RAM depth, instance/descriptor slots, field widths
//   Types   : vertex_t, transform_t, tri_t, geom_op_e, geom_err_e, inst_rec_t, desc_t
//   Helpers : hdr_bad() range check for buffer headers
package vertex_pkg;

   localparam int MAX_VERT = 8192;
   localparam int VA_W     = $clog2(MAX_VERT);
   localparam int MAX_TRI  = 8192;
   localparam int TA_W     = $clog2(MAX_TRI);
   localparam int MAX_INST = 256;
   localparam int MAX_BUF  = 256;
   localparam int MAX_CNT  = 4096;
   localparam int CNT_W    = $clog2(MAX_CNT) + 1;  // count == MAX_CNT is legal
   localparam int VTX_W    = 108;
   localparam int TRI_W    = 36;
   localparam int ID_W     = 8;
   localparam int TRANS_W  = 384;
   localparam int NUM_RD   = 2;
   localparam int SUM_W    = VA_W + 1;             // base+count without overflow

   typedef logic [VTX_W-1:0]   vertex_t;
   typedef logic [TRANS_W-1:0] transform_t;
   typedef logic [TRI_W-1:0]   tri_t;

   typedef enum logic [3:0] {
      OP_VHDR   = 4'd1,
      OP_THDR   = 4'd2,
      OP_CREATE = 4'd3,
      OP_UPDATE = 4'd4
   } geom_op_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_RANGE   = 2'd1,
      ERR_OP      = 2'd2,
      ERR_UNALLOC = 2'd3
   } geom_err_e;

   typedef struct packed {
      transform_t      transform;
      logic [ID_W-1:0] vert_id;
      logic [ID_W-1:0] tri_id;
   } inst_rec_t;

   // Triangle descriptors reuse the vertex-width base; only TA_W bits are meaningful.
   typedef struct packed {
      logic [VA_W-1:0]  base;
      logic [CNT_W-1:0] count;
   } desc_t;

   // Header rejected when the buffer runs past the RAM end or exceeds the element cap.
   function automatic logic hdr_bad(input logic [SUM_W-1:0] base,
                                    input logic [CNT_W-1:0] cnt,
                                    input logic [SUM_W-1:0] lim);
      logic [SUM_W-1:0] sum;
      sum = base + SUM_W'(cnt);
      return (sum > lim) || (cnt > CNT_W'(MAX_CNT));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer returns to channel 0)
//   req_i      : request vector
//   adv_i      : advance strobe; pointer moves to one past the granted channel
//   gnt_o      : one-hot grant, combinational from req_i and pointer
module rr_arbiter
#(
   parameter int N = 2
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;
   int            idx;

   // Scan from the pointer upward (wrapping); first requester wins.
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (adv_i)
         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/geom_store.sv
// geom_store: geometry store for the renderer (vertex/triangle RAMs, buffer
// descriptors, instance records) with a write command/data stream and read ports.
//   clk, rst_n              : raster clock, async active-low reset
//   cmd_*                   : header/instance command stream (ready only when idle)
//   dat_*                   : vertex/triangle data beats (ready only in a data phase)
//   busy, err_valid/err_code: data phase flag, one-cycle error pulse
//   inst_rd_* / *_out       : 2-stage instance resolve (record + both descriptors)
//   vrd_*                   : round-robin arbitrated vertex read, 1-cycle latency
//   tri_rd_* / tri_out      : triangle read, 1-cycle latency
module geom_store
   import vertex_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [ID_W-1:0]          cmd_id,
   input  logic [VA_W-1:0]          cmd_base,
   input  logic [CNT_W-1:0]         cmd_count,
   input  logic [ID_W-1:0]          cmd_vid,
   input  logic [ID_W-1:0]          cmd_tid,
   input  logic [TRANS_W-1:0]       cmd_transform,
   input  logic                     dat_valid,
   output logic                     dat_ready,
   input  logic [VTX_W-1:0]         dat_in,
   output logic                     busy,
   output logic                     err_valid,
   output logic [1:0]               err_code,
   input  logic                     inst_rd_en,
   input  logic [ID_W-1:0]          inst_rd_id,
   output logic                     inst_rd_valid,
   output logic                     inst_hit,
   output transform_t               transform_out,
   output logic [VA_W-1:0]          vert_base_out,
   output logic [CNT_W-1:0]         vert_count_out,
   output logic [TA_W-1:0]          tri_base_out,
   output logic [CNT_W-1:0]         tri_count_out,
   input  logic [NUM_RD-1:0]        vrd_req,
   input  logic [NUM_RD*VA_W-1:0]   vrd_addr,
   output logic [NUM_RD-1:0]        vrd_gnt,
   output logic [NUM_RD-1:0]        vrd_rvalid,
   output vertex_t                  vrd_data,
   input  logic                     tri_rd_en,
   input  logic [TA_W-1:0]          tri_rd_addr,
   output logic                     tri_rd_valid,
   output logic [TRI_W-1:0]         tri_out
);

   typedef enum logic [1:0] {S_IDLE, S_VDATA, S_TDATA} state_e;

   // ---------------- storage (no reset: contents survive rst_n) ----------------
   (* ram_style = "block" *) vertex_t   vram [MAX_VERT];
   (* ram_style = "block" *) tri_t      tram [MAX_TRI];
   (* ram_style = "block" *) inst_rec_t imem [MAX_INST];
   desc_t vdesc [MAX_BUF];
   desc_t tdesc [MAX_BUF];

   // ---------------- control state ----------------
   state_e           state_q;
   logic [VA_W-1:0]  ptr_q;
   logic [CNT_W-1:0] rem_q;
   logic             err_valid_q;
   geom_err_e        err_code_q;
   logic [MAX_INST-1:0] inst_vbm_q;

   geom_op_e op;
   logic     cmd_fire, vhdr_bad, thdr_bad;
   logic     vdesc_we, tdesc_we, inst_we, vram_we, tram_we;

   assign cmd_ready = (state_q == S_IDLE);
   assign dat_ready = (state_q != S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;

   assign op       = geom_op_e'(cmd_op);
   assign cmd_fire = cmd_valid && (state_q == S_IDLE);
   assign vhdr_bad = hdr_bad(SUM_W'(cmd_base), cmd_count, SUM_W'(MAX_VERT));
   assign thdr_bad = hdr_bad(SUM_W'(cmd_base[TA_W-1:0]), cmd_count, SUM_W'(MAX_TRI));
   assign vdesc_we = cmd_fire && (op == OP_VHDR) && !vhdr_bad;
   assign tdesc_we = cmd_fire && (op == OP_THDR) && !thdr_bad;
   assign inst_we  = cmd_fire && ((op == OP_CREATE) ||
                                  ((op == OP_UPDATE) && inst_vbm_q[cmd_id]));
   assign vram_we  = dat_valid && (state_q == S_VDATA);
   assign tram_we  = dat_valid && (state_q == S_TDATA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         inst_vbm_q  <= '0;
      end else begin
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (op)
                     OP_VHDR: begin
                        if (vhdr_bad) begin
                           err_valid_q <= 1'b1;
                           err_code_q  <= ERR_RANGE;
                        end else if (cmd_count != '0) begin
                           ptr_q   <= cmd_base;
                           rem_q   <= cmd_count;
                           state_q <= S_VDATA;
                        end
                     end
                     OP_THDR: begin
                        if (thdr_bad) begin
                           err_valid_q <= 1'b1;
                           err_code_q  <= ERR_RANGE;
                        end else if (cmd_count != '0) begin
                           ptr_q   <= VA_W'(cmd_base[TA_W-1:0]);
                           rem_q   <= cmd_count;
                           state_q <= S_TDATA;
                        end
                     end
                     OP_CREATE: inst_vbm_q[cmd_id] <= 1'b1;
                     OP_UPDATE: begin
                        if (!inst_vbm_q[cmd_id]) begin
                           err_valid_q <= 1'b1;
                           err_code_q  <= ERR_UNALLOC;
                        end
                     end
                     default: begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_OP;
                     end
                  endcase
               end
            end
            default: begin  // S_VDATA / S_TDATA
               if (dat_valid) begin
                  ptr_q <= ptr_q + 1'b1;
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == CNT_W'(1))
                     state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   // ---------------- vertex read port ----------------
   logic [NUM_RD-1:0] vrd_rvalid_q;
   logic [VA_W-1:0]   vrd_sel_addr;
   vertex_t           vrd_raw_q;

   rr_arbiter #(.N(NUM_RD)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (vrd_req),
      .adv_i (|vrd_req),
      .gnt_o (vrd_gnt)
   );

   always_comb begin
      vrd_sel_addr = '0;
      for (int i = 0; i < NUM_RD; i++)
         if (vrd_gnt[i]) vrd_sel_addr = vrd_addr[i*VA_W +: VA_W];
   end

   // Read and write share one block so a same-address collision returns old data.
   always_ff @(posedge clk) begin
      if (vram_we) vram[ptr_q] <= dat_in;
      if (|vrd_gnt) vrd_raw_q <= vram[vrd_sel_addr];
   end

   // ---------------- triangle read port ----------------
   logic tri_rd_valid_q;
   tri_t tri_raw_q;

   always_ff @(posedge clk) begin
      if (tram_we) tram[ptr_q[TA_W-1:0]] <= dat_in[TRI_W-1:0];
      if (tri_rd_en) tri_raw_q <= tram[tri_rd_addr];
   end

   // ---------------- instance resolve pipeline ----------------
   logic [1:0] vld_pipe;       // [0] stage 1, [1] stage 2
   logic       hit1_q, hit2_q;
   inst_rec_t  rec1_q;
   desc_t      vd2_q, td2_q;
   transform_t xf2_q;

   always_ff @(posedge clk) begin
      if (inst_we)  imem[cmd_id]  <= '{transform: cmd_transform, vert_id: cmd_vid, tri_id: cmd_tid};
      if (vdesc_we) vdesc[cmd_id] <= '{base: cmd_base, count: cmd_count};
      if (tdesc_we) tdesc[cmd_id] <= '{base: VA_W'(cmd_base[TA_W-1:0]), count: cmd_count};
      if (inst_rd_en) rec1_q <= imem[inst_rd_id];
      if (vld_pipe[0]) begin
         xf2_q <= rec1_q.transform;
         vd2_q <= vdesc[rec1_q.vert_id];
         td2_q <= tdesc[rec1_q.tri_id];
      end
   end

   // Valid flags carry reset; data registers above do not, so outputs are gated by them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe       <= '0;
         hit1_q         <= 1'b0;
         hit2_q         <= 1'b0;
         vrd_rvalid_q   <= '0;
         tri_rd_valid_q <= 1'b0;
      end else begin
         vld_pipe       <= {vld_pipe[0], inst_rd_en};
         hit1_q         <= inst_rd_en && inst_vbm_q[inst_rd_id];
         hit2_q         <= hit1_q;
         vrd_rvalid_q   <= vrd_gnt;
         tri_rd_valid_q <= tri_rd_en;
      end
   end

   assign inst_rd_valid  = vld_pipe[1];
   assign inst_hit       = hit2_q;
   assign transform_out  = hit2_q ? xf2_q                  : '0;
   assign vert_base_out  = hit2_q ? vd2_q.base             : '0;
   assign vert_count_out = hit2_q ? vd2_q.count            : '0;
   assign tri_base_out   = hit2_q ? td2_q.base[TA_W-1:0]   : '0;
   assign tri_count_out  = hit2_q ? td2_q.count            : '0;

   assign vrd_rvalid   = vrd_rvalid_q;
   assign vrd_data     = (|vrd_rvalid_q) ? vrd_raw_q : '0;
   assign tri_rd_valid = tri_rd_valid_q;
   assign tri_out      = tri_rd_valid_q ? tri_raw_q : '0;

endmodule

// File: tb/tb_geom_store.sv
// tb_geom_store: directed vectors for geom_store with hand-computed expectations.
module tb_geom_store;
   import vertex_pkg::*;

   logic                   clk = 1'b0, rst_n = 1'b0;
   logic                   cmd_valid = 1'b0, cmd_ready;
   logic [3:0]             cmd_op = '0;
   logic [ID_W-1:0]        cmd_id = '0, cmd_vid = '0, cmd_tid = '0;
   logic [VA_W-1:0]        cmd_base = '0;
   logic [CNT_W-1:0]       cmd_count = '0;
   logic [TRANS_W-1:0]     cmd_transform = '0;
   logic                   dat_valid = 1'b0, dat_ready;
   logic [VTX_W-1:0]       dat_in = '0;
   logic                   busy, err_valid;
   logic [1:0]             err_code;
   logic                   inst_rd_en = 1'b0;
   logic [ID_W-1:0]        inst_rd_id = '0;
   logic                   inst_rd_valid, inst_hit;
   transform_t             transform_out;
   logic [VA_W-1:0]        vert_base_out;
   logic [CNT_W-1:0]       vert_count_out, tri_count_out;
   logic [TA_W-1:0]        tri_base_out;
   logic [NUM_RD-1:0]      vrd_req = '0, vrd_gnt, vrd_rvalid;
   logic [NUM_RD*VA_W-1:0] vrd_addr = '0;
   vertex_t                vrd_data;
   logic                   tri_rd_en = 1'b0;
   logic [TA_W-1:0]        tri_rd_addr = '0;
   logic                   tri_rd_valid;
   logic [TRI_W-1:0]       tri_out;

   int n_vec = 0, n_err = 0;

   geom_store dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
      .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_vid(cmd_vid), .cmd_tid(cmd_tid),
      .cmd_transform(cmd_transform),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
      .busy(busy), .err_valid(err_valid), .err_code(err_code),
      .inst_rd_en(inst_rd_en), .inst_rd_id(inst_rd_id),
      .inst_rd_valid(inst_rd_valid), .inst_hit(inst_hit),
      .transform_out(transform_out), .vert_base_out(vert_base_out),
      .vert_count_out(vert_count_out), .tri_base_out(tri_base_out),
      .tri_count_out(tri_count_out),
      .vrd_req(vrd_req), .vrd_addr(vrd_addr), .vrd_gnt(vrd_gnt),
      .vrd_rvalid(vrd_rvalid), .vrd_data(vrd_data),
      .tri_rd_en(tri_rd_en), .tri_rd_addr(tri_rd_addr),
      .tri_rd_valid(tri_rd_valid), .tri_out(tri_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TRANS_W-1:0] got,
                      input logic [TRANS_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Drive/sample point: 1ns after the rising edge.
   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic tri_t tp(input int k);
      return 36'(k * 36'h1_0101_0101 + 36'h0_DEAD_BEEF);
   endfunction

   function automatic vertex_t pat(input int k);
      return {3{tp(k)}};
   endfunction

   function automatic transform_t xf(input int k);
      return {12{32'(k) ^ 32'hC0DE_0000}};
   endfunction

   task automatic cmd(input logic [3:0] op, input logic [ID_W-1:0] id,
                      input logic [VA_W-1:0] base, input logic [CNT_W-1:0] cnt,
                      input logic [ID_W-1:0] vid, input logic [ID_W-1:0] tid,
                      input transform_t t);
      cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_base = base; cmd_count = cnt;
      cmd_vid = vid; cmd_tid = tid; cmd_transform = t;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic vread(input int ch, input logic [VA_W-1:0] a);
      vrd_req = '0; vrd_req[ch] = 1'b1;
      vrd_addr = '0; vrd_addr[ch*VA_W +: VA_W] = a;
      step();
      vrd_req = '0;
   endtask

   task automatic tread(input logic [TA_W-1:0] a);
      tri_rd_en = 1'b1; tri_rd_addr = a;
      step();
      tri_rd_en = 1'b0;
   endtask

   task automatic resolve(input logic [ID_W-1:0] id);
      inst_rd_en = 1'b1; inst_rd_id = id;
      step();
      inst_rd_en = 1'b0;
      step();
   endtask

   initial begin
      logic [NUM_RD-1:0] eg;

      // ---- reset state ----
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_dat_ready", dat_ready, 0);
      chk("rst_err", {err_valid, err_code}, 0);
      chk("rst_inst", {inst_rd_valid, inst_hit}, 0);
      chk("rst_xf", transform_out, 0);
      chk("rst_vrd", {vrd_rvalid, vrd_data}, 0);
      chk("rst_tri", {tri_rd_valid, tri_out}, 0);
      rst_n = 1'b1;
      step();

      // ---- vertex buffer id 5 base 100 count 3, back-to-back beats ----
      cmd(4'd1, 8'd5, 13'd100, 13'd3, 0, 0, '0);
      chk("vhdr_busy", busy, 1);
      chk("vhdr_dat_ready", dat_ready, 1);
      chk("vhdr_cmd_ready", cmd_ready, 0);
      dat_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin dat_in = pat(k); step(); end
      dat_valid = 1'b0;
      chk("vdata_done_busy", busy, 0);

      // ---- triangle buffer id 2 base 20 count 2 ----
      cmd(4'd2, 8'd2, 13'd20, 13'd2, 0, 0, '0);
      dat_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin dat_in = VTX_W'(tp(k)); step(); end
      dat_valid = 1'b0;
      chk("tdata_done_busy", busy, 0);

      for (int k = 0; k < 3; k++) begin
         vread(0, VA_W'(100 + k));
         chk("vread_rvalid", vrd_rvalid, 2'b01);
         chk("vread_data", vrd_data, pat(k));
      end
      tread(13'd21);
      chk("tread_valid", tri_rd_valid, 1);
      chk("tread_data", tri_out, tp(1));

      // ---- instance 9 -> vid 5, tid 2 ----
      cmd(4'd3, 8'd9, 0, 0, 8'd5, 8'd2, xf(9));
      chk("create_noerr", err_valid, 0);
      resolve(8'd9);
      chk("res9_valid", inst_rd_valid, 1);
      chk("res9_hit", inst_hit, 1);
      chk("res9_xf", transform_out, xf(9));
      chk("res9_vbase", vert_base_out, 100);
      chk("res9_vcnt", vert_count_out, 3);
      chk("res9_tbase", tri_base_out, 20);
      chk("res9_tcnt", tri_count_out, 2);

      // ---- range errors; exact fit at RAM end is legal ----
      cmd(4'd1, 8'd4, 13'd8188, 13'd4, 0, 0, '0);
      chk("fit_noerr", err_valid, 0);
      chk("fit_busy", busy, 1);
      dat_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin dat_in = pat(10 + k); step(); end
      dat_valid = 1'b0;
      cmd(4'd1, 8'd6, 13'd8190, 13'd4, 0, 0, '0);
      chk("range_err", {err_valid, err_code}, {1'b1, 2'd1});
      chk("range_cmd_ready", cmd_ready, 1);
      chk("range_busy", busy, 0);
      dat_in = pat(99); dat_valid = 1'b1;   // must be ignored while idle
      step();
      dat_valid = 1'b0;
      chk("range_pulse_end", err_valid, 0);
      vread(0, 13'd8190);
      chk("range_ram_kept", vrd_data, pat(12));
      cmd(4'd2, 8'd6, 13'd0, 13'd4097, 0, 0, '0);
      chk("count_cap_err", {err_valid, err_code}, {1'b1, 2'd1});

      // ---- update before create, bad opcode ----
      cmd(4'd4, 8'd7, 0, 0, 8'd5, 8'd2, xf(1));
      chk("upd_unalloc", {err_valid, err_code}, {1'b1, 2'd3});
      cmd(4'd3, 8'd7, 0, 0, 8'd5, 8'd2, xf(7));
      chk("create7_noerr", err_valid, 0);
      cmd(4'd9, 8'd7, 0, 0, 0, 0, '0);
      chk("bad_op", {err_valid, err_code}, {1'b1, 2'd2});
      cmd(4'd4, 8'd9, 0, 0, 8'd5, 8'd2, xf(19));
      chk("upd9_noerr", err_valid, 0);

      // ---- back-to-back resolves 9 then 7 ----
      inst_rd_en = 1'b1; inst_rd_id = 8'd9;
      step();
      inst_rd_id = 8'd7;
      step();
      inst_rd_en = 1'b0;
      chk("pipe_a_xf", transform_out, xf(19));
      step();
      chk("pipe_b_hit", inst_hit, 1);
      chk("pipe_b_xf", transform_out, xf(7));

      resolve(8'd200);
      chk("miss_valid", {inst_rd_valid, inst_hit}, 2'b10);
      chk("miss_zero", {transform_out, vert_base_out}, 0);

      // ---- count 0 header ----
      cmd(4'd1, 8'd11, 13'd50, 13'd0, 0, 0, '0);
      chk("cnt0_busy", busy, 0);
      chk("cnt0_err", err_valid, 0);
      cmd(4'd3, 8'd12, 0, 0, 8'd11, 8'd2, xf(12));
      resolve(8'd12);
      chk("cnt0_desc", {vert_base_out, vert_count_out}, {13'd50, 13'd0});

      // ---- reset mid data phase ----
      cmd(4'd1, 8'd3, 13'd200, 13'd5, 0, 0, '0);
      dat_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin dat_in = pat(20 + k); step(); end
      dat_valid = 1'b0;
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #2;
      chk("mrst_busy", busy, 0);
      chk("mrst_cmd_ready", cmd_ready, 1);
      chk("mrst_outs", {err_valid, err_code, inst_rd_valid, inst_hit, vrd_rvalid, tri_rd_valid}, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // ---- arbiter: pointer back at channel 0 ----
      vrd_addr = {VA_W'(101), VA_W'(100)};
      vrd_req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         #3;
         chk("arb_gnt", vrd_gnt, eg);
         @(posedge clk); #1;
         chk("arb_rvalid", vrd_rvalid, eg);
         chk("arb_data", vrd_data, (i % 2 == 0) ? pat(0) : pat(1));
      end
      vrd_req = '0;
      step();
      chk("arb_idle", vrd_rvalid, 0);

      vread(1, 13'd200);
      chk("mrst_ram_kept", vrd_data, pat(20));
      resolve(8'd9);
      chk("mrst_bitmap", {inst_rd_valid, inst_hit}, 2'b10);
      cmd(4'd3, 8'd13, 0, 0, 8'd3, 8'd2, xf(13));
      resolve(8'd13);
      chk("mrst_desc", {vert_base_out, vert_count_out}, {13'd200, 13'd5});
      chk("mrst_tdesc", tri_base_out, 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
